// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and constants for the OAM DMA controller.
package oam_dma_ctrl_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } dma_state_t;

  localparam addr_t OAM_BASE     = 16'hFE00;
  localparam addr_t DMA_REG_ADDR = 16'hFF46;
  localparam int    OAM_DMA_LEN  = 160;
  localparam data_t OPEN_BUS     = 8'hFF;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus signals of the OAM DMA controller.
// slave: the controller; master: the CPU/memory environment around it.
interface oam_dma_ctrl_if;
  import oam_dma_ctrl_pkg::*;

  addr_t cpu_addr;
  data_t cpu_w_data;
  logic  cpu_wen;
  data_t cpu_r_data;
  addr_t bus_addr;
  data_t bus_w_data;
  logic  bus_wen;
  data_t bus_r_data;
  logic  dma_active;

  modport slave (
    input  cpu_addr, cpu_w_data, cpu_wen, bus_r_data,
    output cpu_r_data, bus_addr, bus_w_data, bus_wen, dma_active
  );

  modport master (
    output cpu_addr, cpu_w_data, cpu_wen, bus_r_data,
    input  cpu_r_data, bus_addr, bus_w_data, bus_wen, dma_active
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and CPU/DMA bus arbiter.
// A CPU write to the DMA register copies XFER_LEN bytes from {src,8'h00}
// to OAM, holding the shared bus for the whole copy.
// Optional build macro: OAM_DMA_ECHO_ALIAS_EN maps echo-RAM source pages
// 0xE0-0xFF onto 0xC0-0xDF.
//
// state | meaning
// IDLE  | CPU owns the bus, transparent pass-through
// START | one dead cycle after the register write
// READ  | fetch source byte idx into byte_q
// WRITE | store byte_q to OAM_BASE+idx
module oam_dma_ctrl #(
  parameter oam_dma_ctrl_pkg::addr_t OAM_BASE     = oam_dma_ctrl_pkg::OAM_BASE,
  parameter oam_dma_ctrl_pkg::addr_t DMA_REG_ADDR = oam_dma_ctrl_pkg::DMA_REG_ADDR,
  parameter int                      XFER_LEN     = oam_dma_ctrl_pkg::OAM_DMA_LEN,
  parameter oam_dma_ctrl_pkg::data_t OPEN_BUS     = oam_dma_ctrl_pkg::OPEN_BUS
) (
  input  logic               clk,
  input  logic               rst,
  oam_dma_ctrl_if.slave      bus
);
  import oam_dma_ctrl_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  data_t      src_q, src_d;
  logic [7:0] idx_q, idx_d;
  data_t      byte_q, byte_d;
  data_t      src_eff;
  logic       reg_hit;

  assign reg_hit = (bus.cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ECHO_ALIAS_EN
  assign src_eff = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
`else
  assign src_eff = src_q;
`endif

  assign bus.dma_active = (state_q != IDLE);

  // Register state, source page, byte index and the byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 8'h00;
      idx_q   <= 8'h00;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic and the bus/read-data mux.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    idx_d          = idx_q;
    byte_d         = byte_q;
    bus.bus_addr   = bus.cpu_addr;
    bus.bus_w_data = bus.cpu_w_data;
    bus.bus_wen    = 1'b0;
    bus.cpu_r_data = OPEN_BUS;

    case (state_q)
      IDLE: begin
        bus.bus_wen    = bus.cpu_wen & ~reg_hit;
        bus.cpu_r_data = bus.bus_r_data;
      end
      START: begin
        state_d = READ;
      end
      READ: begin
        bus.bus_addr = {src_eff, idx_q};
        byte_d       = bus.bus_r_data;
        state_d      = WRITE;
      end
      WRITE: begin
        bus.bus_addr   = OAM_BASE + {8'h00, idx_q};
        bus.bus_w_data = byte_q;
        bus.bus_wen    = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reg_hit) begin
      bus.cpu_r_data = src_q;
    end

    // A register write restarts the copy from any state; the final OAM
    // write of a running copy still lands in the same cycle.
    if (reg_hit && bus.cpu_wen) begin
      src_d   = bus.cpu_w_data;
      idx_d   = 8'h00;
      state_d = START;
    end
  end

endmodule
